// File: rtl/multicore_pkg.sv
// multicore_pkg: shared types and constants for the fetch stage.
//   FETCH_FIFO_DEPTH : default instruction buffer depth / outstanding request limit
//   PC_INCR          : sequential fetch stride in bytes
//   fetch_entry_t    : buffered instruction paired with its PC
package multicore_pkg;
    localparam int FETCH_FIFO_DEPTH = 4;
    localparam logic [31:0] PC_INCR = 32'd4;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush and a registered head.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   push_i, data_i    : write request and entry (flush wins over push)
//   pop_i             : remove head (ignored when empty or flushing)
//   flush_i           : drop all entries
//   head_o            : registered head entry (zero when empty)
//   empty_o, count_o  : occupancy status
module fetch_fifo
    import multicore_pkg::*;
#(
    parameter int DEPTH = FETCH_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head_q, head_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push_i & ~flush_i;
        do_pop  = pop_i & (count_q != '0) & ~flush_i;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = flush_i ? wr_q : rd_q + AW'(do_pop);
        count_d = flush_i ? '0 : count_q + CW'(do_push) - CW'(do_pop);
        // When the surviving occupancy is only the incoming entry, it bypasses the array into the head.
        head_d  = (count_d == '0) ? '0 :
                  (count_q == CW'(do_pop)) ? data_i : mem_q[rd_d];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign head_o  = head_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with PC, credit-limited cache requests,
// redirect squashing and a buffered valid/ready interface to decode.
//   i_aclk, i_areset_n             : clock, asynchronous active-low reset
//   i_fetch_en                     : allow new cache requests
//   i_br_valid, i_br_addr          : redirect request and target
//   o_icache_req_valid/addr, i_icache_req_ready : cache request channel
//   i_icache_rsp_valid/data        : in-order cache responses
//   o_instr_valid, o_instr, o_instr_pc, i_decode_ready : decode handshake
//   o_perf_starve, o_perf_squash   : saturating counters (only with FETCH_PERF_CNT_EN)
module fetch_unit
    import multicore_pkg::*;
#(
    parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_aclk,
    input  logic        i_areset_n,
    input  logic        i_fetch_en,
    input  logic        i_br_valid,
    input  logic [31:0] i_br_addr,
    output logic        o_icache_req_valid,
    output logic [31:0] o_icache_req_addr,
    input  logic        i_icache_req_ready,
    input  logic        i_icache_rsp_valid,
    input  logic [31:0] i_icache_rsp_data,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_decode_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_starve,
    output logic [31:0] o_perf_squash
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_cnt, live;
    logic          fire, drop, push, pop, empty;
    fetch_entry_t  head;

    always_comb begin
        target = i_br_addr & ~32'h3;
        live   = out_q - drop_q;
        // Credits: requests still expected to land in the FIFO plus current occupancy must fit.
        o_icache_req_valid = i_fetch_en & ~i_br_valid & (out_q < CW'(FIFO_DEPTH)) &
                             (({1'b0, live} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH));
        fire     = o_icache_req_valid & i_icache_req_ready;
        drop     = i_icache_rsp_valid & (drop_q != '0);
        push     = i_icache_rsp_valid & ~drop & ~i_br_valid;
        pop      = ~empty & i_decode_ready & ~i_br_valid;
        out_d    = out_q + CW'(fire) - CW'(i_icache_rsp_valid);
        drop_d   = i_br_valid ? out_q - CW'(i_icache_rsp_valid) : drop_q - CW'(drop);
        pc_d     = i_br_valid ? target : fire ? pc_q + PC_INCR : pc_q;
        rsp_pc_d = i_br_valid ? target : push ? rsp_pc_q + PC_INCR : rsp_pc_q;
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (i_aclk),
        .rst_ni  (i_areset_n),
        .push_i  (push),
        .data_i  ('{pc: rsp_pc_q, instr: i_icache_rsp_data}),
        .pop_i   (pop),
        .flush_i (i_br_valid),
        .head_o  (head),
        .empty_o (empty),
        .count_o (fifo_cnt)
    );

    assign o_icache_req_addr = pc_q;
    assign o_instr_valid     = ~empty;
    assign o_instr           = head.instr;
    assign o_instr_pc        = head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] starve_q, squash_q;
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            starve_q <= '0;
            squash_q <= '0;
        end else begin
            starve_q <= starve_q + 32'((starve_q != '1) & empty & i_decode_ready);
            squash_q <= squash_q + 32'((squash_q != '1) & i_icache_rsp_valid & (drop | i_br_valid));
        end
    end
    assign o_perf_starve = starve_q;
    assign o_perf_squash = squash_q;
`endif
endmodule
